mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the 6502 core's bus (address / wr_data / wr_enable / rd_data).
- Provides:
  - on-chip RAM;
  - writable reset-vector registers at 0xFFFC/0xFFFD;
  - one memory-mapped I/O port.
- A byte-serial program loader holds the core in reset, fills memory, then releases the core so it fetches the reset vector.

Parameters:
RAM_AW, 12, RAM address width; RAM occupies 0x0000 .. 2**RAM_AW-1
RESET_VECTOR, 16'h0200, reset value of the vector registers
IO_ADDR, 16'hD000, I/O output register (write); IO_ADDR+1 is I/O input (read)
RELEASE_CYCLES, 2, cycles the core reset stays asserted after the last load beat (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  16  core bus address
wr_data  in  8  core write data
wr_enable  in  1  core write strobe, sampled at posedge
rd_data  out  8  read data, combinational from address
cpu_resetn  out  1  active-low reset driven to the core
load_start  in  1  pulse: begin a load session
load_addr  in  16  loader byte address
load_data  in  8  loader byte
load_valid  in  1  loader beat valid
load_last  in  1  qualifies the final beat of a session
load_ready  out  1  responder accepts loader beats
load_done  out  1  1-cycle pulse when the core is released
load_err  out  1  sticky: a beat targeted an unmapped address
io_out  out  8  I/O output register
io_strobe  out  1  1-cycle pulse on each core write to IO_ADDR
io_in  in  8  I/O input value

Behaviour:
- Reset state:
  - FSM = IDLE.
  - cpu_resetn=0, load_ready=0, load_done=0, load_err=0, io_out=0, io_strobe=0.
  - Vector registers = RESET_VECTOR (LSB at 0xFFFC, MSB at 0xFFFD).
  - RAM array is not cleared.
- Read decode (combinational, zero latency, active in every state):
  - address < 2**RAM_AW: RAM[address]
  - 0xFFFC: vector LSB; 0xFFFD: vector MSB
  - IO_ADDR+1: io_in; IO_ADDR: io_out
  - anything else: 8'hFF
- Core writes (only in RUN, at posedge with wr_enable=1):
  - RAM range: RAM[address] <= wr_data.
  - IO_ADDR: io_out <= wr_data, with io_strobe=1 on the following cycle only.
  - Vector addresses and unmapped addresses: ignored.
  - Core writes in any other state: ignored.
- FSM states: IDLE, LOAD, RELEASE, RUN.
  - IDLE: cpu_resetn=0. load_start -> LOAD.
  - LOAD:
    - cpu_resetn=0, load_ready=1.
    - A beat is accepted when load_valid && load_ready at posedge.
    - Each beat writes load_data to RAM or to a vector register, or sets load_err if the address is unmapped.
    - I/O addresses are unmapped for the loader.
    - A beat with load_last=1 -> RELEASE; load_ready=0 from the next cycle.
    - load_start in LOAD is ignored.
  - RELEASE: cpu_resetn=0 for exactly RELEASE_CYCLES cycles (down-counter), then -> RUN.
  - RUN:
    - cpu_resetn=1 from the first RUN cycle; load_done=1 for that first cycle only.
    - load_start in RUN -> LOAD; cpu_resetn=0 on the same edge. io_out and RAM are retained.
- load_err clears only on reset or on entry to LOAD.
- Reset mid-load or mid-release: return to IDLE. Partially loaded RAM bytes remain; vector registers revert to RESET_VECTOR.
- Addresses are full 16-bit compares; no aliasing or wrap of RAM into higher space.

Test Plan:
- Reset then load_start; 3 beats {0x0200:0xEA, 0xFFFC:0x00, 0xFFFD:0x02 last} -> load_ready high for 3 cycles; cpu_resetn low for 2 cycles after the last beat; load_done 1-cycle pulse; rd_data@0xFFFC=0x00, @0x0200=0xEA.
- In RUN, core writes 0x5A to 0x0010, then drives address=0x0010 -> rd_data=0x5A in the same cycle; a core write of 0x12 to 0xFFFC leaves rd_data@0xFFFC unchanged.
- In RUN, core writes 0x81 to 0xD000 -> io_out=0x81, io_strobe high exactly 1 cycle. io_in=0x3C, address=0xD001 -> rd_data=0x3C.
- Loader beat to 0x8000 -> load_err=1 and stays set through RUN; a new load_start clears it. Core read of 0x8000 returns 0xFF.
- load_valid low for 2 cycles mid-session -> no writes occur and the FSM stays in LOAD; load_start pulses during LOAD are ignored.
- Assert reset during RELEASE -> FSM IDLE, cpu_resetn=0, vectors read 0x00/0x02 (RESET_VECTOR 0x0200), previously loaded RAM bytes intact.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// Bus bundle between the 6502 core / program loader side and the memory responder.
// The master side is the core plus loader; the slave side is mem_bus_responder.
interface mem_bus_responder_if;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;
  logic [7:0]  rd_data;
  logic        cpu_resetn;
  logic        load_start;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic [7:0]  io_out;
  logic        io_strobe;
  logic [7:0]  io_in;

  modport slave (
    input  address, wr_data, wr_enable, load_start, load_addr, load_data,
           load_valid, load_last, io_in,
    output rd_data, cpu_resetn, load_ready, load_done, load_err, io_out, io_strobe
  );

  modport master (
    output address, wr_data, wr_enable, load_start, load_addr, load_data,
           load_valid, load_last, io_in,
    input  rd_data, cpu_resetn, load_ready, load_done, load_err, io_out, io_strobe
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for a 6502 core: RAM, writable reset vector, one I/O port,
// and a byte-serial loader that holds the core in reset while memory is filled.
module mem_bus_responder #(
  parameter int          RAM_AW         = 12,
  parameter logic [15:0] RESET_VECTOR   = 16'h0200,
  parameter logic [15:0] IO_ADDR        = 16'hD000,
  parameter int          RELEASE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  mem_bus_responder_if.slave  bus
);

  localparam logic [16:0] RAM_SIZE    = 17'(1) << RAM_AW;
  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
  localparam logic [15:0] IO_IN_ADDR  = IO_ADDR + 16'd1;
  localparam int          CNT_W       = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       vec_lo_q, vec_lo_d;
  logic [7:0]       vec_hi_q, vec_hi_d;
  logic [7:0]       io_out_q, io_out_d;
  logic             io_strobe_q, io_strobe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]        ram_q [2**RAM_AW];
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  logic       core_in_ram;
  logic       load_in_ram;
  logic [7:0] rd_data_c;

  assign core_in_ram = {1'b0, bus.address}   < RAM_SIZE;
  assign load_in_ram = {1'b0, bus.load_addr} < RAM_SIZE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_lo_d    = vec_lo_q;
    vec_hi_d    = vec_hi_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    ram_we      = 1'b0;
    ram_waddr   = bus.address[RAM_AW-1:0];
    ram_wdata   = bus.wr_data;

    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        // The I/O window is deliberately not reachable from the loader.
        if (bus.load_valid) begin
          if (load_in_ram) begin
            ram_we    = 1'b1;
            ram_waddr = bus.load_addr[RAM_AW-1:0];
            ram_wdata = bus.load_data;
          end else if (bus.load_addr == VEC_LO_ADDR) begin
            vec_lo_d = bus.load_data;
          end else if (bus.load_addr == VEC_HI_ADDR) begin
            vec_hi_d = bus.load_data;
          end else begin
            err_d = 1'b1;
          end
          if (bus.load_last) begin
            state_d = RELEASE;
            cnt_d   = CNT_INIT;
          end
        end
      end

      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (bus.wr_enable) begin
          if (core_in_ram) begin
            ram_we = 1'b1;
          end else if (bus.address == IO_ADDR) begin
            io_out_d    = bus.wr_data;
            io_strobe_d = 1'b1;
          end
        end
        if (bus.load_start) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_lo_q    <= RESET_VECTOR[7:0];
      vec_hi_q    <= RESET_VECTOR[15:8];
      io_out_q    <= 8'h00;
      io_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_lo_q    <= vec_lo_d;
      vec_hi_q    <= vec_hi_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // RAM contents survive reset so a partial load is still visible afterwards.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    rd_data_c = 8'hFF;
    if (core_in_ram) begin
      rd_data_c = ram_q[bus.address[RAM_AW-1:0]];
    end else if (bus.address == VEC_LO_ADDR) begin
      rd_data_c = vec_lo_q;
    end else if (bus.address == VEC_HI_ADDR) begin
      rd_data_c = vec_hi_q;
    end else if (bus.address == IO_IN_ADDR) begin
      rd_data_c = bus.io_in;
    end else if (bus.address == IO_ADDR) begin
      rd_data_c = io_out_q;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.cpu_resetn = (state_q == RUN);
  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;
  assign bus.io_out     = io_out_q;
  assign bus.io_strobe  = io_strobe_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder, checked against a flat memory-map model
// (byte array + vector/io/error variables) updated by loader beats and core writes.
module tb_mem_bus_responder;

  localparam int RELEASE_CYCLES = 2;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_responder_if bus();

  mem_bus_responder #(
    .RAM_AW(12),
    .RESET_VECTOR(16'h0200),
    .IO_ADDR(16'hD000),
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]  ram_m [0:4095];
  bit          ram_known [0:4095];
  logic [7:0]  vec_lo_m, vec_hi_m, io_m;
  bit          err_m;
  logic [15:0] touched_q [$];
  beat_t       beats [$];
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model_read(input logic [15:0] a);
    if (a < 16'h1000) return {ram_known[a[11:0]], ram_m[a[11:0]]};
    if (a == 16'hFFFC) return {1'b1, vec_lo_m};
    if (a == 16'hFFFD) return {1'b1, vec_hi_m};
    if (a == 16'hD001) return {1'b1, bus.io_in};
    if (a == 16'hD000) return {1'b1, io_m};
    return {1'b1, 8'hFF};
  endfunction

  function automatic void model_load_beat(input logic [15:0] a, input logic [7:0] d);
    if (a < 16'h1000) begin
      ram_m[a[11:0]] = d;
      ram_known[a[11:0]] = 1'b1;
      touched_q.push_back(a);
    end else if (a == 16'hFFFC) vec_lo_m = d;
    else if (a == 16'hFFFD) vec_hi_m = d;
    else err_m = 1'b1;
  endfunction

  function automatic bit model_core_write(input logic [15:0] a, input logic [7:0] d);
    if (a < 16'h1000) begin
      ram_m[a[11:0]] = d;
      ram_known[a[11:0]] = 1'b1;
      touched_q.push_back(a);
      return 1'b0;
    end
    if (a == 16'hD000) begin
      io_m = d;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] gen_load_addr();
    int r = $urandom_range(9, 0);
    if (r <= 5) return {4'h0, 12'($urandom)};
    if (r == 6) return 16'hFFFC;
    if (r == 7) return 16'hFFFD;
    if (r == 8) return ($urandom_range(1, 0) != 0) ? 16'hD000 : 16'hD001;
    return 16'h1000 + 16'($urandom_range(16'hAFFF, 0));
  endfunction

  function automatic logic [15:0] gen_core_addr();
    int r = $urandom_range(6, 0);
    if (r <= 3) return {4'h0, 12'($urandom)};
    if (r == 4) return 16'hD000;
    if (r == 5) return ($urandom_range(1, 0) != 0) ? 16'hFFFC : 16'hFFFD;
    return ($urandom_range(1, 0) != 0) ? 16'hD001 : (16'h1000 + 16'($urandom_range(16'hAFFF, 0)));
  endfunction

  function automatic void make_random_beats(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.addr = gen_load_addr();
      b.data = 8'($urandom);
      beats.push_back(b);
    end
  endfunction

  function automatic void add_beat(input logic [15:0] a, input logic [7:0] d);
    beat_t b;
    b.addr = a;
    b.data = d;
    beats.push_back(b);
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    vec_lo_m = 8'h00;
    vec_hi_m = 8'h02;
    io_m = 8'h00;
    err_m = 1'b0;
    checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_resetn got=%b exp=0", bus.cpu_resetn); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_ready got=%b exp=0", bus.load_ready); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done got=%b exp=0", bus.load_done); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err got=%b exp=0", bus.load_err); end
    checks++; if (bus.io_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_io_out got=%h exp=00", bus.io_out); end
    checks++; if (bus.io_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_io_strobe got=%b exp=0", bus.io_strobe); end
    reset = 1'b0;
    tick;
    checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL idle_cpu_resetn got=%b exp=0", bus.cpu_resetn); end
    bus.address = 16'hFFFC; #1;
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_vec_lo got=%h exp=00", bus.rd_data); end
    bus.address = 16'hFFFD; #1;
    checks++; if (bus.rd_data !== 8'h02) begin errors++; $display("[TB] FAIL reset_vec_hi got=%h exp=02", bus.rd_data); end
    bus.address = 16'h8000; #1;
    checks++; if (bus.rd_data !== 8'hFF) begin errors++; $display("[TB] FAIL unmapped_read got=%h exp=FF", bus.rd_data); end
  endtask

  // One complete load session from the current beats queue; optionally resets mid-release.
  task automatic test_load_session(input int gap_max, input bit abort_release);
    int ready_cycles = 0;
    int exp_ready = 0;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    err_m = 1'b0;
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("[TB] FAIL load_entry_err got=%b exp=0", bus.load_err); end
    checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL load_cpu_resetn got=%b exp=0", bus.cpu_resetn); end
    foreach (beats[i]) begin
      int gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        logic [15:0] junk = (touched_q.size() > 0) ? touched_q[$urandom_range(touched_q.size() - 1, 0)] : 16'h0200;
        logic [8:0]  jm = model_read(junk);
        bus.load_valid = 1'b0;
        bus.load_addr  = junk;
        bus.load_data  = ~jm[7:0];
        bus.load_last  = 1'($urandom_range(1, 0));
        bus.load_start = 1'($urandom_range(1, 0));
        bus.address    = junk;
        bus.wr_data    = ~jm[7:0];
        bus.wr_enable  = 1'b1;
        if (bus.load_ready) ready_cycles++;
        exp_ready++;
        tick;
      end
      bus.wr_enable  = 1'b0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_addr  = beats[i].addr;
      bus.load_data  = beats[i].data;
      bus.load_last  = (i == beats.size() - 1);
      if (bus.load_ready) ready_cycles++;
      exp_ready++;
      tick;
      model_load_beat(beats[i].addr, beats[i].data);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    checks++; if (ready_cycles != exp_ready) begin errors++; $display("[TB] FAIL load_ready_cycles got=%0d exp=%0d", ready_cycles, exp_ready); end
    for (int r = 0; r < RELEASE_CYCLES; r++) begin
      checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL release_cpu_resetn cycle=%0d got=%b exp=0", r, bus.cpu_resetn); end
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_load_ready cycle=%0d got=%b exp=0", r, bus.load_ready); end
      checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL release_load_done cycle=%0d got=%b exp=0", r, bus.load_done); end
      if (abort_release) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vec_lo_m = 8'h00;
        vec_hi_m = 8'h02;
        io_m = 8'h00;
        err_m = 1'b0;
        return;
      end
      tick;
    end
    checks++; if (bus.cpu_resetn !== 1'b1) begin errors++; $display("[TB] FAIL run_cpu_resetn got=%b exp=1", bus.cpu_resetn); end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("[TB] FAIL load_done_pulse got=%b exp=1", bus.load_done); end
    checks++; if (bus.load_err !== err_m) begin errors++; $display("[TB] FAIL load_err_run got=%b exp=%b", bus.load_err, err_m); end
    tick;
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL load_done_width got=%b exp=0", bus.load_done); end
    checks++; if (bus.cpu_resetn !== 1'b1) begin errors++; $display("[TB] FAIL run_hold_cpu_resetn got=%b exp=1", bus.cpu_resetn); end
    foreach (beats[i]) begin
      logic [8:0] m = model_read(beats[i].addr);
      bus.address = beats[i].addr;
      #1;
      m = model_read(beats[i].addr);
      if (m[8]) begin
        checks++; if (bus.rd_data !== m[7:0]) begin errors++; $display("[TB] FAIL load_readback addr=%h got=%h exp=%h", beats[i].addr, bus.rd_data, m[7:0]); end
      end
    end
  endtask

  task automatic test_basic_load;
    beats.delete();
    add_beat(16'h0200, 8'hEA);
    add_beat(16'hFFFC, 8'h00);
    add_beat(16'hFFFD, 8'h02);
    test_load_session(0, 1'b0);
    bus.address = 16'hFFFC; #1;
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("[TB] FAIL basic_vec_lo got=%h exp=00", bus.rd_data); end
    bus.address = 16'h0200; #1;
    checks++; if (bus.rd_data !== 8'hEA) begin errors++; $display("[TB] FAIL basic_ram_0200 got=%h exp=EA", bus.rd_data); end
  endtask

  task automatic test_random_core_writes(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a = gen_core_addr();
      logic [7:0]  d = 8'($urandom);
      bit          exp_strobe;
      logic [8:0]  m;
      bus.io_in     = 8'($urandom);
      bus.address   = a;
      bus.wr_data   = d;
      bus.wr_enable = 1'b1;
      tick;
      bus.wr_enable = 1'b0;
      exp_strobe = model_core_write(a, d);
      checks++; if (bus.io_strobe !== exp_strobe) begin errors++; $display("[TB] FAIL core_io_strobe addr=%h got=%b exp=%b", a, bus.io_strobe, exp_strobe); end
      m = model_read(a);
      if (m[8]) begin
        checks++; if (bus.rd_data !== m[7:0]) begin errors++; $display("[TB] FAIL core_readback addr=%h got=%h exp=%h", a, bus.rd_data, m[7:0]); end
      end
    end
  endtask

  task automatic test_core_write;
    bus.address   = 16'h0010;
    bus.wr_data   = 8'h5A;
    bus.wr_enable = 1'b1;
    tick;
    bus.wr_enable = 1'b0;
    void'(model_core_write(16'h0010, 8'h5A));
    checks++; if (bus.rd_data !== 8'h5A) begin errors++; $display("[TB] FAIL core_ram_0010 got=%h exp=5A", bus.rd_data); end
    bus.address   = 16'hFFFC;
    bus.wr_data   = 8'h12;
    bus.wr_enable = 1'b1;
    tick;
    bus.wr_enable = 1'b0;
    checks++; if (bus.rd_data !== vec_lo_m) begin errors++; $display("[TB] FAIL core_vec_write_ignored got=%h exp=%h", bus.rd_data, vec_lo_m); end
    test_random_core_writes(20);
  endtask

  task automatic test_io;
    bus.address   = 16'hD000;
    bus.wr_data   = 8'h81;
    bus.wr_enable = 1'b1;
    tick;
    bus.wr_enable = 1'b0;
    io_m = 8'h81;
    checks++; if (bus.io_out !== 8'h81) begin errors++; $display("[TB] FAIL io_out got=%h exp=81", bus.io_out); end
    checks++; if (bus.io_strobe !== 1'b1) begin errors++; $display("[TB] FAIL io_strobe_high got=%b exp=1", bus.io_strobe); end
    tick;
    checks++; if (bus.io_strobe !== 1'b0) begin errors++; $display("[TB] FAIL io_strobe_width got=%b exp=0", bus.io_strobe); end
    bus.io_in   = 8'h3C;
    bus.address = 16'hD001; #1;
    checks++; if (bus.rd_data !== 8'h3C) begin errors++; $display("[TB] FAIL io_in_read got=%h exp=3C", bus.rd_data); end
    bus.address = 16'hD000; #1;
    checks++; if (bus.rd_data !== 8'h81) begin errors++; $display("[TB] FAIL io_out_read got=%h exp=81", bus.rd_data); end
  endtask

  task automatic test_load_err;
    beats.delete();
    add_beat(16'h8000, 8'h11);
    add_beat(16'h0300, 8'h22);
    add_beat(16'h0301, 8'h33);
    test_load_session(0, 1'b0);
    repeat (4) tick;
    checks++; if (bus.load_err !== 1'b1) begin errors++; $display("[TB] FAIL load_err_sticky got=%b exp=1", bus.load_err); end
    bus.address = 16'h8000; #1;
    checks++; if (bus.rd_data !== 8'hFF) begin errors++; $display("[TB] FAIL read_8000 got=%h exp=FF", bus.rd_data); end
  endtask

  task automatic test_gaps;
    make_random_beats(6);
    test_load_session(2, 1'b0);
    foreach (touched_q[i]) begin
      logic [8:0] m = model_read(touched_q[i]);
      bus.address = touched_q[i];
      #1;
      checks++; if (bus.rd_data !== m[7:0]) begin errors++; $display("[TB] FAIL gap_no_write addr=%h got=%h exp=%h", touched_q[i], bus.rd_data, m[7:0]); end
    end
  endtask

  task automatic test_random_sessions;
    for (int s = 0; s < 3; s++) begin
      make_random_beats($urandom_range(8, 3));
      test_load_session(2, 1'b0);
      test_random_core_writes(8);
    end
  endtask

  task automatic test_reset_release;
    beats.delete();
    add_beat(16'h0400, 8'hA5);
    add_beat(16'hFFFC, 8'h34);
    add_beat(16'hFFFD, 8'h12);
    test_load_session(0, 1'b1);
    checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL abort_cpu_resetn got=%b exp=0", bus.cpu_resetn); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_load_ready got=%b exp=0", bus.load_ready); end
    checks++; if (bus.io_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_io_out got=%h exp=00", bus.io_out); end
    bus.address = 16'hFFFC; #1;
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_vec_lo got=%h exp=00", bus.rd_data); end
    bus.address = 16'hFFFD; #1;
    checks++; if (bus.rd_data !== 8'h02) begin errors++; $display("[TB] FAIL abort_vec_hi got=%h exp=02", bus.rd_data); end
    bus.address = 16'h0400; #1;
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL abort_ram_0400 got=%h exp=A5", bus.rd_data); end
    repeat (3) tick;
    checks++; if (bus.cpu_resetn !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_hold got=%b exp=0", bus.cpu_resetn); end
    foreach (touched_q[i]) begin
      logic [8:0] m = model_read(touched_q[i]);
      bus.address = touched_q[i];
      #1;
      checks++; if (bus.rd_data !== m[7:0]) begin errors++; $display("[TB] FAIL abort_ram_kept addr=%h got=%h exp=%h", touched_q[i], bus.rd_data, m[7:0]); end
    end
    make_random_beats(4);
    test_load_session(1, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.address    = 16'h0000;
    bus.wr_data    = 8'h00;
    bus.wr_enable  = 1'b0;
    bus.load_start = 1'b0;
    bus.load_addr  = 16'h0000;
    bus.load_data  = 8'h00;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.io_in      = 8'h00;
    $display("[TB] starting mem_bus_responder bench");
    test_reset;
    test_basic_load;
    test_core_write;
    test_io;
    test_load_err;
    test_gaps;
    test_random_sessions;
    test_reset_release;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
